// File: rtl/ysyx_23060236_exu_pkg.sv
// rtl/ysyx_23060236_exu_pkg.sv - shared encodings and helpers for the execute stage
package ysyx_23060236_exu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        CT_ALU    = 3'd0,
        CT_LOAD   = 3'd1,
        CT_STORE  = 3'd2,
        CT_BRANCH = 3'd3,
        CT_JAL    = 3'd4,
        CT_JALR   = 3'd5
    } ctrl_type_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Undefined branch conditions never redirect.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060236_exu_if.sv
// rtl/ysyx_23060236_exu_if.sv - IDU-to-EXU and EXU-to-LSU handshake bundle
interface ysyx_23060236_exu_if;
    logic        idu_valid;
    logic        idu_ready;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  src_sel;
    logic [2:0]  funct3_in;
    logic [2:0]  ctrl_type;
    logic [4:0]  rd_in;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] exu_val;
    logic [31:0] lsu_data;
    logic [2:0]  funct3;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [4:0]  rd;
    logic        jump_wrong;
    logic [31:0] jump_target;

    modport master (
        output idu_valid, pc, src1, src2, imm, alu_op, src_sel, funct3_in, ctrl_type, rd_in, exu_ready,
        input  idu_ready, exu_valid, exu_val, lsu_data, funct3, lsu_ren, lsu_wen, rd, jump_wrong, jump_target
    );

    modport slave (
        input  idu_valid, pc, src1, src2, imm, alu_op, src_sel, funct3_in, ctrl_type, rd_in, exu_ready,
        output idu_ready, exu_valid, exu_val, lsu_data, funct3, lsu_ren, lsu_wen, rd, jump_wrong, jump_target
    );
endinterface

// File: rtl/ysyx_23060236_Reg.sv
// rtl/ysyx_23060236_Reg.sv - resettable register with write enable
module ysyx_23060236_Reg #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end
endmodule

// File: rtl/ysyx_23060236_exu_alu.sv
// rtl/ysyx_23060236_exu_alu.sv - combinational integer ALU
module ysyx_23060236_alu
    import ysyx_23060236_exu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'b0, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_23060236_exu.sv
// rtl/ysyx_23060236_exu.sv - one-entry execute stage with not-taken branch resolution
module ysyx_23060236_exu
    import ysyx_23060236_exu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    ysyx_23060236_exu_if.slave   bus
);
    ctrl_type_e  ct;
    logic [31:0] op_a, op_b, alu_res;
    logic [31:0] pc_plus4, ls_addr, target, val_next;
    logic        taken, mispredict, accept, handoff;
    logic        valid_q, jw_q;
    logic [31:0] val_q, data_q, target_q;
    logic [2:0]  f3_q;
    logic        ren_q, wen_q;
    logic [4:0]  rd_q;

    assign ct       = ctrl_type_e'(bus.ctrl_type);
    assign op_a     = bus.src_sel[0] ? bus.pc  : bus.src1;
    assign op_b     = bus.src_sel[1] ? bus.imm : bus.src2;
    assign pc_plus4 = bus.pc + 32'd4;
    assign ls_addr  = bus.src1 + bus.imm;

    ysyx_23060236_alu u_alu (
        .op     (alu_op_e'(bus.alu_op)),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res)
    );

    always_comb begin
        val_next = alu_res;
        taken    = 1'b0;
        target   = bus.pc + bus.imm;
        case (ct)
            CT_ALU:            val_next = alu_res;
            CT_LOAD, CT_STORE: val_next = ls_addr;
            CT_BRANCH: begin
                val_next = '0;
                taken    = branch_taken(bus.funct3_in, bus.src1, bus.src2);
            end
            CT_JAL: begin
                val_next = pc_plus4;
                taken    = 1'b1;
            end
            CT_JALR: begin
                val_next = pc_plus4;
                taken    = 1'b1;
                target   = ls_addr & ~32'h1;
            end
            default:           val_next = alu_res;
        endcase
    end

    // Fetch already proceeded to pc+4, so only a different target needs a flush.
    assign mispredict    = taken & (target != pc_plus4);
    assign bus.idu_ready = (~valid_q | bus.exu_ready) & ~jw_q;
    assign accept        = bus.idu_valid & bus.idu_ready;
    assign handoff       = valid_q & bus.exu_ready;

    ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
        .clock (clock), .reset (reset), .wen (accept | handoff), .din (accept), .dout (valid_q)
    );

    ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_jump_wrong (
        .clock (clock), .reset (reset), .wen (1'b1), .din (accept & mispredict), .dout (jw_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q    <= '0;
            data_q   <= '0;
            f3_q     <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            target_q <= '0;
        end else if (accept) begin
            val_q  <= val_next;
            data_q <= bus.src2;
            f3_q   <= bus.funct3_in;
            ren_q  <= (ct == CT_LOAD);
            wen_q  <= (ct == CT_STORE);
            rd_q   <= (ct == CT_STORE || ct == CT_BRANCH) ? 5'd0 : bus.rd_in;
            if (mispredict) begin
                target_q <= target;
            end
        end
    end

    assign bus.exu_valid   = valid_q;
    assign bus.jump_wrong  = jw_q;
    assign bus.exu_val     = val_q;
    assign bus.lsu_data    = data_q;
    assign bus.funct3      = f3_q;
    assign bus.lsu_ren     = ren_q;
    assign bus.lsu_wen     = wen_q;
    assign bus.rd          = rd_q;
    assign bus.jump_target = target_q;
endmodule

// File: tb/tb_ysyx_23060236_exu.sv
// tb/tb_ysyx_23060236_exu.sv - randomized and directed bench for the execute stage
module tb_ysyx_23060236_exu;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ysyx_23060236_exu_if bus ();

    ysyx_23060236_exu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] val;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        ren;
        logic        wen;
        logic [4:0]  rd;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;

    logic        ev;
    logic        ejw;
    logic [31:0] ejt;
    ent_t        eent;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t ref_exec(input logic [31:0] pc, s1, s2, imm, input int op,
                                      input logic [1:0] sel, input logic [2:0] f3,
                                      input int ct, input logic [4:0] rd);
        ent_t e;
        logic [31:0] a, b, r;
        int sh;
        logic tk;
        a  = sel[0] ? pc : s1;
        b  = sel[1] ? imm : s2;
        sh = int'(b % 32);
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a << sh;
            3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: r = (a < b) ? 32'd1 : 32'd0;
            5: r = a ^ b;
            6: r = a >> sh;
            7: r = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            8: r = a | b;
            9: r = a & b;
            default: r = b;
        endcase
        tk = 1'b0;
        if (ct == 3) begin
            case (f3)
                3'd0: tk = (s1 == s2);
                3'd1: tk = (s1 != s2);
                3'd4: tk = ($signed(s1) < $signed(s2));
                3'd5: tk = ($signed(s1) >= $signed(s2));
                3'd6: tk = (s1 < s2);
                3'd7: tk = (s1 >= s2);
                default: tk = 1'b0;
            endcase
        end else if (ct == 4 || ct == 5) begin
            tk = 1'b1;
        end
        e.tgt  = (ct == 5) ? ((s1 + imm) & 32'hFFFFFFFE) : (pc + imm);
        e.mis  = tk && (e.tgt != pc + 32'd4);
        e.val  = (ct == 0) ? r : (ct == 1 || ct == 2) ? s1 + imm : (ct == 3) ? 32'd0 : pc + 32'd4;
        e.data = s2;
        e.f3   = f3;
        e.ren  = (ct == 1);
        e.wen  = (ct == 2);
        e.rd   = (ct == 2 || ct == 3) ? 5'd0 : rd;
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("exu_valid", bus.exu_valid, ev);
        check_eq("jump_wrong", bus.jump_wrong, ejw);
        if (ev) begin
            check_eq("exu_val", bus.exu_val, eent.val);
            check_eq("lsu_data", bus.lsu_data, eent.data);
            check_eq("funct3", bus.funct3, eent.f3);
            check_eq("lsu_ren", bus.lsu_ren, eent.ren);
            check_eq("lsu_wen", bus.lsu_wen, eent.wen);
            check_eq("rd", bus.rd, eent.rd);
        end
        if (ejw) check_eq("jump_target", bus.jump_target, ejt);
    endtask

    // Called at the falling edge; drives one cycle of inputs and advances the model.
    task automatic step(input logic iv, er, input logic [31:0] pc, s1, s2, imm, input int op,
                        input logic [1:0] sel, input logic [2:0] f3, input int ct, input logic [4:0] rd);
        ent_t n;
        logic rdy;
        bus.idu_valid = iv;
        bus.exu_ready = er;
        bus.pc        = pc;
        bus.src1      = s1;
        bus.src2      = s2;
        bus.imm       = imm;
        bus.alu_op    = 4'(op);
        bus.src_sel   = sel;
        bus.funct3_in = f3;
        bus.ctrl_type = 3'(ct);
        bus.rd_in     = rd;
        #1;
        rdy = (!ev || er) && !ejw;
        check_eq("idu_ready", bus.idu_ready, rdy);
        n = ref_exec(pc, s1, s2, imm, op, sel, f3, ct, rd);
        if (iv && rdy) begin
            ev   = 1'b1;
            eent = n;
            ejw  = n.mis;
            if (n.mis) ejt = n.tgt;
        end else begin
            ejw = 1'b0;
            if (ev && er) ev = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input logic er);
        step(1'b0, er, 32'h0, 32'h0, 32'h0, 32'h0, 0, 2'b00, 3'd0, 0, 5'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.idu_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ev = 1'b0; ejw = 1'b0; ejt = 32'h0;
        check_eq("rst_exu_valid", bus.exu_valid, 32'd0);
        check_eq("rst_jump_wrong", bus.jump_wrong, 32'd0);
        check_eq("rst_lsu_ren", bus.lsu_ren, 32'd0);
        check_eq("rst_lsu_wen", bus.lsu_wen, 32'd0);
        check_eq("rst_exu_val", bus.exu_val, 32'd0);
        check_eq("rst_lsu_data", bus.lsu_data, 32'd0);
        check_eq("rst_jump_target", bus.jump_target, 32'd0);
        check_eq("rst_funct3", bus.funct3, 32'd0);
        check_eq("rst_rd", bus.rd, 32'd0);
        check_eq("rst_idu_ready", bus.idu_ready, 32'd1);
    endtask

    task automatic rand_step();
        logic [31:0] pc, s1, s2, imm;
        int ct;
        pc  = $urandom & 32'hFFFFFFFC;
        s1  = $urandom;
        s2  = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
        imm = ($urandom_range(0, 7) == 0) ? 32'd4 : $urandom;
        ct  = $urandom_range(0, 5);
        if (ct == 5 && $urandom_range(0, 3) == 0) s1 = pc + 32'd4 - imm;
        step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, pc, s1, s2, imm,
             $urandom_range(0, 10), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ct,
             5'($urandom_range(0, 31)));
    endtask

    logic [31:0] held;

    initial begin
        checks = 0;
        errors = 0;
        clock  = 1'b0;
        reset  = 1'b1;
        bus.idu_valid = 1'b0; bus.exu_ready = 1'b0; bus.pc = '0; bus.src1 = '0; bus.src2 = '0;
        bus.imm = '0; bus.alu_op = '0; bus.src_sel = '0; bus.funct3_in = '0; bus.ctrl_type = '0;
        bus.rd_in = '0;
        do_reset();

        step(1'b1, 1'b1, 32'h0, 32'd5, 32'd7, 32'h0, 0, 2'b00, 3'd0, 0, 5'd9);
        check_eq("add_valid", bus.exu_valid, 32'd1);
        check_eq("add_val", bus.exu_val, 32'd12);
        check_eq("add_rd", bus.rd, 32'd9);

        step(1'b1, 1'b1, 32'h0, 32'h80000000, 32'd4, 32'h0, 7, 2'b00, 3'd0, 0, 5'd1);
        check_eq("sra_val", bus.exu_val, 32'hF8000000);
        step(1'b1, 1'b1, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 4, 2'b00, 3'd0, 0, 5'd1);
        check_eq("sltu_val", bus.exu_val, 32'd1);

        step(1'b1, 1'b1, 32'h0, 32'h1000, 32'h0, 32'hFFFFFFFC, 0, 2'b10, 3'b010, 1, 5'd3);
        check_eq("load_val", bus.exu_val, 32'hFFC);
        check_eq("load_ren", bus.lsu_ren, 32'd1);
        check_eq("load_wen", bus.lsu_wen, 32'd0);

        step(1'b1, 1'b1, 32'h100, 32'h55, 32'h55, 32'h20, 0, 2'b00, 3'b000, 3, 5'd7);
        check_eq("beq_jw", bus.jump_wrong, 32'd1);
        check_eq("beq_target", bus.jump_target, 32'h120);
        check_eq("beq_idu_ready", bus.idu_ready, 32'd0);
        check_eq("beq_rd", bus.rd, 32'd0);
        step(1'b1, 1'b1, 32'h0, 32'd1, 32'd2, 32'h0, 0, 2'b00, 3'd0, 0, 5'd4);
        check_eq("beq_jw_drop", bus.jump_wrong, 32'd0);

        step(1'b1, 1'b1, 32'h80, 32'h203, 32'h0, 32'h0, 0, 2'b00, 3'd0, 5, 5'd1);
        check_eq("jalr_val", bus.exu_val, 32'h84);
        check_eq("jalr_target", bus.jump_target, 32'h202);
        check_eq("jalr_jw", bus.jump_wrong, 32'd1);
        idle(1'b1);

        step(1'b1, 1'b1, 32'h40, 32'h0, 32'h0, 32'd4, 0, 2'b00, 3'd0, 4, 5'd2);
        check_eq("jal_seq_jw", bus.jump_wrong, 32'd0);
        check_eq("jal_seq_val", bus.exu_val, 32'h44);

        step(1'b1, 1'b1, 32'h0, 32'd30, 32'd8, 32'h0, 0, 2'b00, 3'd0, 0, 5'd5);
        held = bus.exu_val;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 1, 2'b00, 3'd0, 0, 5'd6);
            check_eq("stall_val", bus.exu_val, held);
            check_eq("stall_idu_ready", bus.idu_ready, 32'd0);
        end
        step(1'b1, 1'b1, 32'h0, 32'd30, 32'd8, 32'h0, 1, 2'b00, 3'd0, 0, 5'd6);
        check_eq("swap_valid", bus.exu_valid, 32'd1);
        check_eq("swap_val", bus.exu_val, 32'd22);

        for (int i = 0; i < 400; i++) rand_step();

        step(1'b1, 1'b0, 32'h0, 32'd3, 32'd4, 32'h0, 0, 2'b00, 3'd0, 0, 5'd8);
        do_reset();
        for (int i = 0; i < 200; i++) rand_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
